// File: rtl/sys_bridge_arb.sv
// sys_bridge_arb: two-master (CPU, loader) to three-device bridge with
// round-robin arbitration, address decode, access checking and a fixed
// three-phase IDLE -> ACCESS -> RESP transaction.
// Optional feature macro: BRIDGE_TC1_EN enables the timer1 window; without it
// the timer1 window decodes as a miss and tc1_sel stays low.
module sys_bridge_arb #(
   parameter logic [31:0] DM_TOP   = 32'h0000_2fff,
   parameter logic [31:0] TC0_BASE = 32'h0000_7f00,
   parameter logic [31:0] TC1_BASE = 32'h0000_7f10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_be,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_be,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        dm_sel,
   output logic        tc0_sel,
   output logic        tc1_sel,
   output logic        dev_we,
   output logic [31:0] dev_addr,
   output logic [31:0] dev_wdata,
   output logic [3:0]  dev_be,
   input  logic [31:0] dm_rdata,
   input  logic [31:0] tc0_rdata,
   input  logic [31:0] tc1_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic [1:0] {TGT_NONE, TGT_DM, TGT_TC0, TGT_TC1} tgt_t;

   state_t      state_q, state_d;
   tgt_t        tgt_q, tgt_d, dec_tgt;
   logic        ptr_q, ptr_d;
   logic        owner_q, owner_d;
   logic        err_q, err_d;
   logic        dev_we_q, dev_we_d;
   logic [31:0] dev_addr_q, dev_addr_d;
   logic [31:0] dev_wdata_q, dev_wdata_d;
   logic [3:0]  dev_be_q, dev_be_d;
   logic        dm_sel_q, dm_sel_d;
   logic        tc0_sel_q, tc0_sel_d;
   logic        tc1_sel_q, tc1_sel_d;
   logic        m0_rvalid_q, m0_rvalid_d;
   logic        m1_rvalid_q, m1_rvalid_d;

   logic        grant_m0, grant_m1, can_grant;
   logic        sel_we;
   logic [31:0] sel_addr, sel_wdata;
   logic [3:0]  sel_be;
   logic        in_dm, in_tc0, in_tc1, is_timer;
   logic        misalign, timer_be_bad, count_wr, acc_err;
   logic [31:0] off0;
   logic [31:0] resp_rdata;

   // A lone requester always wins; on a tie the pointer decides.
   assign grant_m0  = m0_req && (!m1_req || !ptr_q);
   assign grant_m1  = m1_req && (!m0_req ||  ptr_q);
   assign can_grant = reset && (state_q == IDLE);
   assign m0_gnt    = can_grant && grant_m0;
   assign m1_gnt    = can_grant && grant_m1;

   assign sel_we    = grant_m1 ? m1_we    : m0_we;
   assign sel_addr  = grant_m1 ? m1_addr  : m0_addr;
   assign sel_wdata = grant_m1 ? m1_wdata : m0_wdata;
   assign sel_be    = grant_m1 ? m1_be    : m0_be;

   assign off0   = sel_addr - TC0_BASE;
   assign in_dm  = (sel_addr <= DM_TOP);
   assign in_tc0 = (sel_addr >= TC0_BASE) && (sel_addr <= TC0_BASE + 32'd11);

`ifdef BRIDGE_TC1_EN
   logic [31:0] off1;
   assign off1     = sel_addr - TC1_BASE;
   assign in_tc1   = (sel_addr >= TC1_BASE) && (sel_addr <= TC1_BASE + 32'd11);
   assign count_wr = sel_we && ((in_tc0 && (off0 >= 32'd8)) || (in_tc1 && (off1 >= 32'd8)));
   assign tc1_sel  = tc1_sel_q;
`else
   logic unused_tc1;
   assign in_tc1     = 1'b0;
   assign count_wr   = sel_we && in_tc0 && (off0 >= 32'd8);
   assign tc1_sel    = 1'b0;
   assign unused_tc1 = ^{tc1_rdata, TC1_BASE, tc1_sel_q};
`endif

   assign is_timer     = in_tc0 || in_tc1;
   assign misalign     = ((sel_be == 4'hF) && (sel_addr[1:0] != 2'b00)) ||
                         (((sel_be == 4'h3) || (sel_be == 4'hC)) && sel_addr[0]);
   assign timer_be_bad = is_timer && (sel_be != 4'hF);
   assign acc_err      = !(in_dm || is_timer) || misalign || timer_be_bad || count_wr;

   // Decode the selected master's address into a device target.
   always_comb begin
      dec_tgt = TGT_NONE;
      if (in_dm)       dec_tgt = TGT_DM;
      else if (in_tc0) dec_tgt = TGT_TC0;
      else if (in_tc1) dec_tgt = TGT_TC1;
   end

   // Next-state logic: latch at grant, strobe in ACCESS, complete in RESP.
   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      err_d       = err_q;
      dev_we_d    = dev_we_q;
      dev_addr_d  = dev_addr_q;
      dev_wdata_d = dev_wdata_q;
      dev_be_d    = dev_be_q;
      dm_sel_d    = 1'b0;
      tc0_sel_d   = 1'b0;
      tc1_sel_d   = 1'b0;
      m0_rvalid_d = 1'b0;
      m1_rvalid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               state_d     = ACCESS;
               owner_d     = grant_m1;
               ptr_d       = !grant_m1;
               err_d       = acc_err;
               tgt_d       = acc_err ? TGT_NONE : dec_tgt;
               dev_we_d    = sel_we;
               dev_addr_d  = sel_addr;
               dev_wdata_d = sel_wdata;
               dev_be_d    = sel_be;
               dm_sel_d    = !acc_err && (dec_tgt == TGT_DM);
               tc0_sel_d   = !acc_err && (dec_tgt == TGT_TC0);
               tc1_sel_d   = !acc_err && (dec_tgt == TGT_TC1);
            end
         end
         ACCESS: begin
            state_d     = RESP;
            m0_rvalid_d = !owner_q;
            m1_rvalid_d = owner_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         tgt_q       <= TGT_NONE;
         ptr_q       <= 1'b0;
         owner_q     <= 1'b0;
         err_q       <= 1'b0;
         dev_we_q    <= 1'b0;
         dev_addr_q  <= 32'd0;
         dev_wdata_q <= 32'd0;
         dev_be_q    <= 4'd0;
         dm_sel_q    <= 1'b0;
         tc0_sel_q   <= 1'b0;
         tc1_sel_q   <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         err_q       <= err_d;
         dev_we_q    <= dev_we_d;
         dev_addr_q  <= dev_addr_d;
         dev_wdata_q <= dev_wdata_d;
         dev_be_q    <= dev_be_d;
         dm_sel_q    <= dm_sel_d;
         tc0_sel_q   <= tc0_sel_d;
         tc1_sel_q   <= tc1_sel_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
      end
   end

   // Device read data arrives the cycle after the strobe, i.e. during RESP.
   always_comb begin
      resp_rdata = 32'd0;
      if (!dev_we_q && !err_q) begin
         case (tgt_q)
            TGT_DM:  resp_rdata = dm_rdata;
            TGT_TC0: resp_rdata = tc0_rdata;
`ifdef BRIDGE_TC1_EN
            TGT_TC1: resp_rdata = tc1_rdata;
`endif
            default: resp_rdata = 32'd0;
         endcase
      end
   end

   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m0_err    = m0_rvalid_q && err_q;
   assign m1_err    = m1_rvalid_q && err_q;
   assign m0_rdata  = m0_rvalid_q ? resp_rdata : 32'd0;
   assign m1_rdata  = m1_rvalid_q ? resp_rdata : 32'd0;
   assign dm_sel    = dm_sel_q;
   assign tc0_sel   = tc0_sel_q;
   assign dev_we    = dev_we_q;
   assign dev_addr  = dev_addr_q;
   assign dev_wdata = dev_wdata_q;
   assign dev_be    = dev_be_q;

endmodule

// File: tb/tb_sys_bridge_arb.sv
// tb_sys_bridge_arb: directed table-driven bench for sys_bridge_arb plus
// hand-written sequences for arbitration order and reset abort.
module tb_sys_bridge_arb;

   logic        clk;
   logic        reset;
   logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_be;
   logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_be;
   logic        dm_sel, tc0_sel, tc1_sel, dev_we;
   logic [31:0] dev_addr, dev_wdata;
   logic [3:0]  dev_be;
   logic [31:0] dm_rdata, tc0_rdata, tc1_rdata;

   int checkCount = 0;
   int failCount  = 0;

   typedef struct packed {
      logic        master;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [2:0]  expSel;
      logic        expErr;
      logic [31:0] expRdata;
   } vec_t;

   localparam int NUM_VECS = 14;
   vec_t vecs [NUM_VECS];

   sys_bridge_arb dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .dm_sel(dm_sel), .tc0_sel(tc0_sel), .tc1_sel(tc1_sel),
      .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_be(dev_be),
      .dm_rdata(dm_rdata), .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value and report a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Drive one master's request fields from a vector.
   task automatic applyStimulus(input vec_t v);
      if (v.master) begin
         m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_be = v.be;
      end else begin
         m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_be = v.be;
      end
   endtask

   // Run one single-master transaction and check every phase.
   task automatic runTxn(input int idx, input vec_t v);
      int waited = 0;
      @(negedge clk);
      applyStimulus(v);
      #1;
      while (!(v.master ? m1_gnt : m0_gnt) && waited < 8) begin
         @(negedge clk); #1;
         waited++;
      end
      checkOutput($sformatf("v%0d_gnt", idx), {31'd0, v.master ? m1_gnt : m0_gnt}, 32'd1);
      checkOutput($sformatf("v%0d_gnt_other", idx), {31'd0, v.master ? m0_gnt : m1_gnt}, 32'd0);
      @(negedge clk);
      m0_req = 1'b0; m1_req = 1'b0;
      #1;
      checkOutput($sformatf("v%0d_strobe", idx), {29'd0, tc1_sel, tc0_sel, dm_sel}, {29'd0, v.expSel});
      checkOutput($sformatf("v%0d_early_rvalid", idx), {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      if (v.expSel != 3'b000) begin
         checkOutput($sformatf("v%0d_dev_we", idx), {31'd0, dev_we}, {31'd0, v.we});
         checkOutput($sformatf("v%0d_dev_addr", idx), dev_addr, v.addr);
         checkOutput($sformatf("v%0d_dev_be", idx), {28'd0, dev_be}, {28'd0, v.be});
         if (v.we) checkOutput($sformatf("v%0d_dev_wdata", idx), dev_wdata, v.wdata);
      end
      @(negedge clk); #1;
      checkOutput($sformatf("v%0d_rvalid", idx), {30'd0, m1_rvalid, m0_rvalid},
                  v.master ? 32'd2 : 32'd1);
      checkOutput($sformatf("v%0d_err", idx), {31'd0, v.master ? m1_err : m0_err}, {31'd0, v.expErr});
      checkOutput($sformatf("v%0d_rdata", idx), v.master ? m1_rdata : m0_rdata, v.expRdata);
      checkOutput($sformatf("v%0d_other_resp", idx),
                  (v.master ? m0_rdata : m1_rdata) | {31'd0, v.master ? m0_err : m1_err}, 32'd0);
      checkOutput($sformatf("v%0d_strobe_off", idx), {29'd0, tc1_sel, tc0_sel, dm_sel}, 32'd0);
      checkOutput($sformatf("v%0d_dev_addr_hold", idx), dev_addr, v.addr);
   endtask

   // Main sequence: reset values, arbitration, vector table, reset abort.
   initial begin
      reset = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = 32'd0; m0_be = 4'hF;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h7f00; m1_wdata = 32'd0; m1_be = 4'hF;
      dm_rdata = 32'hDEAD_BEEF; tc0_rdata = 32'h0C0C_0001; tc1_rdata = 32'h0C1C_0002;

      vecs[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 3'b001, 1'b0, 32'hDEAD_BEEF};
      vecs[1]  = '{1'b1, 1'b1, 32'h0000_7f08, 32'h5,         4'hF, 3'b000, 1'b1, 32'h0};
      vecs[2]  = '{1'b1, 1'b1, 32'h0000_7f04, 32'h1234,      4'hF, 3'b010, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 32'h0000_3000, 32'h0,         4'hF, 3'b000, 1'b1, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0000_0002, 32'h0,         4'hF, 3'b000, 1'b1, 32'h0};
`ifdef BRIDGE_TC1_EN
      vecs[5]  = '{1'b0, 1'b0, 32'h0000_7f14, 32'h0,         4'hF, 3'b100, 1'b0, 32'h0C1C_0002};
`else
      vecs[5]  = '{1'b0, 1'b0, 32'h0000_7f14, 32'h0,         4'hF, 3'b000, 1'b1, 32'h0};
`endif
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_7f08, 32'h0,         4'hF, 3'b010, 1'b0, 32'h0C0C_0001};
      vecs[7]  = '{1'b0, 1'b0, 32'h0000_7f00, 32'h0,         4'h3, 3'b000, 1'b1, 32'h0};
      vecs[8]  = '{1'b1, 1'b1, 32'h0000_2ffc, 32'hA5A5_5A5A, 4'hF, 3'b001, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0000_2fff, 32'h0,         4'h1, 3'b001, 1'b0, 32'hDEAD_BEEF};
      vecs[10] = '{1'b0, 1'b0, 32'h0000_0001, 32'h0,         4'hC, 3'b000, 1'b1, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0002, 32'h0,         4'hC, 3'b001, 1'b0, 32'hDEAD_BEEF};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_7f0c, 32'h0,         4'hF, 3'b000, 1'b1, 32'h0};
      vecs[13] = '{1'b0, 1'b1, 32'h0000_7f1c, 32'h77,        4'hF, 3'b000, 1'b1, 32'h0};

      // Reset values while both masters request.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      checkOutput("rst_strobes", {29'd0, tc1_sel, tc0_sel, dm_sel}, 32'd0);
      checkOutput("rst_rvalid_err", {28'd0, m1_rvalid, m0_rvalid, m1_err, m0_err}, 32'd0);
      checkOutput("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      checkOutput("rst_dev", dev_addr | dev_wdata | {27'd0, dev_we, dev_be}, 32'd0);

      // Simultaneous requests right after reset release: m0 first.
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("arb1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
      @(negedge clk);
      m0_req = 1'b0;
      #1;
      checkOutput("arb1_strobe", {29'd0, tc1_sel, tc0_sel, dm_sel}, 32'd1);
      checkOutput("arb1_busy_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      @(negedge clk); #1;
      checkOutput("arb1_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
      checkOutput("arb1_rdata", m0_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      m0_req = 1'b1;
      #1;
      checkOutput("arb2_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
      @(negedge clk);
      m1_req = 1'b0;
      #1;
      checkOutput("arb2_strobe", {29'd0, tc1_sel, tc0_sel, dm_sel}, 32'd2);
      checkOutput("arb2_busy_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      @(negedge clk); #1;
      checkOutput("arb2_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd2);
      checkOutput("arb2_rdata", m1_rdata, 32'h0C0C_0001);
      @(negedge clk);
      m1_req = 1'b1;
      #1;
      checkOutput("arb3_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
      @(negedge clk);
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (2) @(negedge clk);

      // Directed vector table.
      for (int i = 0; i < NUM_VECS; i++) runTxn(i, vecs[i]);

      // Reset during ACCESS aborts the transaction.
      @(negedge clk);
      applyStimulus(vecs[0]);
      #1;
      checkOutput("abort_gnt", {31'd0, m0_gnt}, 32'd1);
      @(negedge clk);
      m0_req = 1'b0;
      #1;
      checkOutput("abort_strobe_before", {31'd0, dm_sel}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("abort_outputs_zero",
                  {27'd0, dm_sel, tc0_sel, tc1_sel, m0_rvalid, dev_we} | dev_addr | dev_wdata, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checkOutput($sformatf("abort_quiet%0d", c),
                     {27'd0, m0_rvalid, m1_rvalid, dm_sel, tc0_sel, tc1_sel}, 32'd0);
         @(negedge clk);
      end
      runTxn(99, vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
